// File: rtl/rom_pkg.sv
// Shared types and iNES image constants for the ROM loader and rom_master.
package rom_pkg;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE,
    LD_ERROR
  } rom_ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [31:0] INES_MAGIC     = 32'h4E45531A;
  localparam int unsigned INES_HDR_BYTES = 16;
  localparam int unsigned PRG_BYTES      = 16384;
  localparam int unsigned CHR_BYTES      = 8192;
  localparam logic [15:0] CHR_BASE       = 16'h4010;

  // Offsets 0-7 of an NROM header; offsets 6/7 only need mapper nibble zero.
  function automatic logic hdr_byte_ok(input logic [2:0] off, input logic [7:0] b);
    case (off)
      3'd0:    return b == INES_MAGIC[31:24];
      3'd1:    return b == INES_MAGIC[23:16];
      3'd2:    return b == INES_MAGIC[15:8];
      3'd3:    return b == INES_MAGIC[7:0];
      3'd4:    return b == 8'h01;
      3'd5:    return b == 8'h01;
      default: return b[7:4] == 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 LSB-first serial receiver with 2-flop input synchroniser and start-bit glitch rejection.
module uart_rx
  import rom_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 186
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_din,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_ferr
);

  localparam int unsigned    CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state;
  logic          r_din_s1, r_din_s2, r_din_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_din_s1   <= 1'b1;
      r_din_s2   <= 1'b1;
      r_din_prev <= 1'b1;
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      o_rx_valid <= 1'b0;
      o_rx_ferr  <= 1'b0;
      o_rx_byte  <= '0;
    end else begin
      r_din_s1   <= i_din;
      r_din_s2   <= r_din_s1;
      r_din_prev <= r_din_s2;
      o_rx_valid <= 1'b0;
      o_rx_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_din_prev && !r_din_s2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_state <= r_din_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_din_s2, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_din_s2) begin
              o_rx_valid <= 1'b1;
              o_rx_byte  <= r_shift;
            end else begin
              o_rx_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Serial iNES loader: writes each received byte at its file offset, holding CPU/PPU in reset.
// Optional header check enabled by ROM_LOADER_HDR_CHECK_EN.
module rom_loader
  import rom_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 186,
  parameter int unsigned IMAGE_BYTES  = INES_HDR_BYTES + PRG_BYTES + CHR_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prg_ctrl,
  input  logic        din,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  localparam logic [15:0] IMG_END = 16'(IMAGE_BYTES);

  rom_ld_state_t r_state;
  logic [15:0]   r_cnt;
  logic          r_prg_s1, r_prg_s2, r_prg_prev;
  logic          w_prg_rise;
  logic          w_rx_valid, w_rx_ferr, w_hdr_bad;
  logic [7:0]    w_rx_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_din      (din),
    .o_rx_valid (w_rx_valid),
    .o_rx_byte  (w_rx_byte),
    .o_rx_ferr  (w_rx_ferr)
  );

  assign w_prg_rise = r_prg_s2 && !r_prg_prev;

`ifdef ROM_LOADER_HDR_CHECK_EN
  assign w_hdr_bad = (r_cnt < 16'd8) && !hdr_byte_ok(r_cnt[2:0], w_rx_byte);
`else
  assign w_hdr_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prg_s1   <= 1'b0;
      r_prg_s2   <= 1'b0;
      r_prg_prev <= 1'b0;
      r_state    <= LD_IDLE;
      r_cnt      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      r_prg_s1   <= prg_ctrl;
      r_prg_s2   <= r_prg_s1;
      r_prg_prev <= r_prg_s2;
      wr_en      <= 1'b0;
      // Restart outranks a byte arriving on the same cycle; that byte is dropped.
      if (w_prg_rise) begin
        r_state  <= LD_LOAD;
        r_cnt    <= '0;
        busy     <= 1'b1;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
      end else if (r_state == LD_LOAD) begin
        if (r_cnt == IMG_END) begin
          r_state  <= LD_DONE;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          done     <= 1'b1;
        end else if (w_rx_ferr || (w_rx_valid && w_hdr_bad)) begin
          r_state <= LD_ERROR;
          busy    <= 1'b0;
          err     <= 1'b1;
        end else if (w_rx_valid) begin
          wr_en   <= 1'b1;
          wr_addr <= r_cnt;
          wr_data <= w_rx_byte;
          r_cnt   <= r_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader against a byte-level load model; follows ROM_LOADER_HDR_CHECK_EN.
module tb_rom_loader;

  localparam int unsigned CPB    = 8;
  localparam int unsigned IMG    = 40;
  localparam int unsigned BIT_NS = CPB * 10;

  logic        clk = 1'b0;
  logic        rst, prg_ctrl, din;
  logic        wr_en, busy, done, err, cpu_hold;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  rom_loader #(.CLKS_PER_BIT(CPB), .IMAGE_BYTES(IMG)) dut (
    .clk      (clk),
    .rst      (rst),
    .prg_ctrl (prg_ctrl),
    .din      (din),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (wr_en) obs_q.push_back({wr_addr, wr_data});
    if (wr_en && prev_we) chk("we_back_to_back", 32'd1, 32'd0);
    prev_we <= wr_en;
  end

  // Reference model: a load is a byte stream written at consecutive offsets.
  int m_cnt = 0;
  bit m_load = 0, m_done = 0, m_err = 0;
  logic [7:0] img[IMG];

  function automatic bit hdr_ok(input int off, input logic [7:0] b);
    logic [7:0] magic[6] = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h01};
    if (off < 6) return b == magic[off];
    if (off < 8) return b < 8'd16;
    return 1'b1;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit stop);
    if (!m_load) return;
    if (!stop) begin m_load = 0; m_err = 1; return; end
`ifdef ROM_LOADER_HDR_CHECK_EN
    if (!hdr_ok(m_cnt, b)) begin m_load = 0; m_err = 1; return; end
`endif
    exp_q.push_back({m_cnt[15:0], b});
    m_cnt++;
    if (m_cnt == IMG) begin m_load = 0; m_done = 1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    din = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      #(BIT_NS);
    end
    din = stop;
    #(BIT_NS);
    din = 1'b1;
    #30;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    model_byte(b, stop);
    send_frame(b, stop);
  endtask

  task automatic arm();
    prg_ctrl = 1'b1;
    #40;
    prg_ctrl = 1'b0;
    #40;
    m_cnt = 0; m_load = 1; m_done = 0; m_err = 0;
  endtask

  task automatic make_image();
    img[0] = 8'h4E; img[1] = 8'h45; img[2] = 8'h53; img[3] = 8'h1A;
    img[4] = 8'h01; img[5] = 8'h01;
    img[6] = 8'($urandom_range(0, 15));
    img[7] = 8'($urandom_range(0, 15));
    for (int i = 8; i < IMG; i++) img[i] = 8'($urandom);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_write"}, {8'h0, obs_q[i]}, {8'h0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    #50;
    compare_writes(tag);
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_busy"}, busy, m_load);
    chk({tag, "_hold"}, cpu_hold, m_load | m_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_hold"}, cpu_hold, 0);
  endtask

  initial begin
    din = 1'b1; prg_ctrl = 1'b0; rst = 1'b1;
    #23;
    check_reset_outputs("reset");
    rst = 1'b0;
    #20;

    // Full valid image, preceded by a short din glitch while the receiver is idle
    make_image();
    arm();
    chk("arm_busy", busy, 1);
    chk("arm_hold", cpu_hold, 1);
    @(negedge clk); din = 1'b0;
    @(negedge clk); @(negedge clk); din = 1'b1;
    #200;
    chk("glitch_nowrite", obs_q.size(), 0);
    for (int i = 0; i < IMG; i++) send_byte(img[i], 1'b1);
    check_status("full");

    // Bad PRG bank count in header
    make_image();
    img[4] = 8'h02;
    arm();
    for (int i = 0; i < IMG; i++) send_byte(img[i], 1'b1);
    check_status("hdr4");

    // Framing error on byte 10
    make_image();
    arm();
    for (int i = 0; i < IMG; i++) send_byte(img[i], i != 10);
    check_status("ferr");

    // Restart part-way, then a full image
    make_image();
    arm();
    for (int i = 0; i < 15; i++) send_byte(img[i], 1'b1);
    check_status("partial");
    make_image();
    arm();
    for (int i = 0; i < IMG; i++) send_byte(img[i], 1'b1);
    check_status("restart");

    // Reset in the middle of a frame
    make_image();
    arm();
    for (int i = 0; i < 5; i++) send_byte(img[i], 1'b1);
    din = 1'b0;
    #200;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    din = 1'b1;
    #20;
    rst = 1'b0;
    m_load = 0; m_done = 0; m_err = 0;
    #20;
    compare_writes("pre_rst");
    for (int i = 5; i < 10; i++) send_byte(img[i], 1'b1);
    check_status("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Serial programming front-end for `rom_master`. It receives an NROM iNES image (16 KB PRG, 8 KB CHR) over an RS232 line (8N1), checks the 16-byte header, and writes every file byte into the ROM image array through a byte write port. The write address equals the file offset. While loading, it holds the CPU/PPU in reset. It sits upstream of `rom_master` and replaces the power-on `$readmemh` image at run time.

## Interface
Parameters:
- `CLKS_PER_BIT`, 186: clk cycles per serial bit. Must be ≥ 4.
- `IMAGE_BYTES`, 24592: total bytes accepted. This is 16 header + 16384 PRG + 8192 CHR.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: **asynchronous, active-high reset**.
- `prg_ctrl` in 1: arm/restart request. Asynchronous to `clk`; the block synchronises it.
- `din` in 1: serial RX line. Idle high, asynchronous to `clk`; the block synchronises it.
- `wr_en` out 1: one-cycle write strobe to the ROM array.
- `wr_addr` out 16: ROM array byte address, equal to the file offset.
- `wr_data` out 8: byte to write.
- `busy` out 1: high in LOAD.
- `done` out 1: high after a complete, valid image has been written.
- `err` out 1: high after a header or framing error.
- `cpu_hold` out 1: reset request to CPU/PPU. High in LOAD and ERROR.

## Operation
- Input synchronisation:
  - `din` and `prg_ctrl` each pass through a 2-flop synchroniser.
  - A `prg_ctrl` rising edge is detected on the synchronised signal.
- Serial receive, 8N1, LSB first:
  - A falling edge on synchronised `din` starts a frame.
  - `din` is resampled at `CLKS_PER_BIT/2`. If it is high, the frame is treated as a glitch and the receiver returns to idle.
  - Data bits are sampled every `CLKS_PER_BIT` after that.
  - The stop bit is sampled one period after bit 7.
  - Stop bit = 1: pulse `rx_valid` for one cycle with `rx_byte`.
  - Stop bit = 0: pulse `rx_ferr` instead.
- FSM states: IDLE, LOAD, DONE, ERROR.
  - Reset → IDLE.
  - A `prg_ctrl` rising edge in any state → LOAD. This clears the byte counter, `done` and `err`.
  - LOAD with `rx_valid`:
    - Write the byte at the current counter value, then increment the counter.
    - When the counter reaches `IMAGE_BYTES`, go to DONE.
  - LOAD with `rx_ferr` → ERROR.
  - LOAD with a header mismatch → ERROR. The offending byte is not written.
  - Bytes received in IDLE, DONE or ERROR are discarded and generate no writes.
- Header check, applied to offsets 0–7:
  - Offsets 0–3 must be 4E 45 53 1A.
  - Offset 4 must be 01 (PRG banks).
  - Offset 5 must be 01 (CHR banks).
  - Offsets 6 and 7 must have bits [7:4] = 0 (mapper 0).
  - Offsets 8–15 are unchecked and written as received.
- Counter is 16 bits; `wr_addr` is the counter value at the time of the write. The counter never wraps, because a load ends at `IMAGE_BYTES` − 1 < 2^16.
- Simultaneous `prg_ctrl` edge and `rx_valid`: the restart wins, the byte is discarded and no write occurs.
- A `prg_ctrl` edge mid-frame does not reset the serial receiver. That frame completes and becomes byte 0 of the new load.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0, `cpu_hold`=0. The FSM is in IDLE and the receiver is idle.
- Byte latency:
  - `rx_valid` occurs at the stop-bit sample point.
  - `wr_en`, `wr_addr` and `wr_data` are registered and valid on the next clk, for exactly one cycle.
- FSM transitions and outputs:
  - `busy` and `cpu_hold` rise the cycle after the synchronised `prg_ctrl` edge is detected.
  - `done` rises and `cpu_hold` falls the cycle after the final write strobe.
  - `err` rises the cycle after the error event. `cpu_hold` stays 1 in ERROR.
- Max throughput is one byte per 10·`CLKS_PER_BIT` cycles, so `wr_en` is never high on consecutive cycles.
- Reset asserted mid-load: all outputs return to reset values immediately. The ROM contents already written stay partial.

## Configuration
- `ROM_LOADER_HDR_CHECK_EN`:
  - Defined: the header check above is active, and a mismatch → ERROR.
  - Undefined: no header comparison. All `IMAGE_BYTES` bytes are written blindly, and only framing errors reach ERROR.

## Structure
- `rom_pkg` holds:
  - the state enum `rom_ld_state_t`;
  - `INES_MAGIC` (32'h4E45531A);
  - `INES_HDR_BYTES`=16;
  - `PRG_BYTES`=16384 and `CHR_BYTES`=8192;
  - `CHR_BASE`=16'h4010.
  `rom_master` addressing uses the same constants.
- One sub-module, `uart_rx`. It contains the synchroniser, bit timer and shift register, and outputs `rx_valid`, `rx_byte` and `rx_ferr`. The FSM, counter and header check live in `rom_loader`.

## Test plan
- Valid 24592-byte image at `CLKS_PER_BIT`=8:
  - 24592 writes, with addresses 0..24591 in order and data matching the file.
  - Afterwards `done`=1, `err`=0, `cpu_hold`=0.
- Header byte 4 = 02:
  - Writes occur at addresses 0–3 only; address 4 is not written.
  - `err`=1, `cpu_hold`=1.
  - With the macro undefined, all bytes are written and `done`=1.
- Stop bit forced 0 on byte 100: no write at address 100, `err`=1.
- `prg_ctrl` pulse after 5000 bytes, then a full image:
  - Writes restart at address 0.
  - `done` is set only after 24592 more bytes.
- `rst` pulse mid-load: all outputs at reset values on the same edge. Bytes sent afterwards produce no writes until a `prg_ctrl` edge.
- 2-cycle low glitch on `din` while idle: no `rx_valid` and no write.
